// File: rtl/register_fall_shift_nb.sv
// register_fall_shift_nb
//   N-bit falling-edge register for the 6502 datapath (A/X/Y). It can hold,
//   load, shift, rotate, increment or decrement its contents. It also keeps
//   registered carry, zero and negative status flags. All state changes on the
//   falling edge of clock, so the outputs stay stable through the next high
//   phase for rising-edge consumers.
//
// Parameters
//   WIDTH        data width, >= 2
//   RESET_VALUE  value loaded into out on reset
//
// Ports
//   clock      in   system clock (falling-edge active)
//   reset_n    in   synchronous active-low reset, sampled on the falling edge
//   mode       in   3-bit operation select (HOLD/LOAD/SHL/SHR/ROL/ROR/INC/DEC)
//   in         in   parallel load data
//   carry_in   in   bit shifted in by ROL/ROR
//   out        out  register contents
//   carry_out  out  bit shifted out by the last shift/rotate
//   zero       out  1 when out == 0
//   negative   out  copy of out[WIDTH-1]
module register_fall_shift_nb #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] in,
  input  logic             carry_in,
  output logic [WIDTH-1:0] out,
  output logic             carry_out,
  output logic             zero,
  output logic             negative
);

  localparam logic [2:0] M_HOLD = 3'd0;
  localparam logic [2:0] M_LOAD = 3'd1;
  localparam logic [2:0] M_SHL  = 3'd2;
  localparam logic [2:0] M_SHR  = 3'd3;
  localparam logic [2:0] M_ROL  = 3'd4;
  localparam logic [2:0] M_ROR  = 3'd5;
  localparam logic [2:0] M_INC  = 3'd6;
  localparam logic [2:0] M_DEC  = 3'd7;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] nxt;
  logic             nxt_c;

  // Next-state datapath. The carry defaults to its current value, so only
  // the shift and rotate modes change it.
  always_comb begin
    nxt   = out;
    nxt_c = carry_out;
    unique case (mode)
      M_HOLD: ;
      M_LOAD: nxt = in;
      M_SHL: begin
        nxt   = {out[WIDTH-2:0], 1'b0};
        nxt_c = out[WIDTH-1];
      end
      M_SHR: begin
        nxt   = {1'b0, out[WIDTH-1:1]};
        nxt_c = out[0];
      end
      M_ROL: begin
        nxt   = {out[WIDTH-2:0], carry_in};
        nxt_c = out[WIDTH-1];
      end
      M_ROR: begin
        nxt   = {carry_in, out[WIDTH-1:1]};
        nxt_c = out[0];
      end
      M_INC: nxt = out + ONE;   // wraps modulo 2^WIDTH
      M_DEC: nxt = out - ONE;
      default: ;
    endcase
  end

  // HOLD leaves every output register untouched, including the flags. Every
  // other mode derives zero and negative from the new value, not the old one.
  always_ff @(negedge clock) begin
    if (!reset_n) begin
      out       <= RESET_VALUE;
      carry_out <= 1'b0;
      zero      <= (RESET_VALUE == '0);
      negative  <= RESET_VALUE[WIDTH-1];
    end else if (mode != M_HOLD) begin
      out       <= nxt;
      carry_out <= nxt_c;
      zero      <= (nxt == '0);
      negative  <= nxt[WIDTH-1];
    end
  end

endmodule

// File: tb/tb_register_fall_shift_nb.sv
module tb_register_fall_shift_nb;

  localparam logic [2:0] HOLD = 3'd0, LOAD = 3'd1, SHL = 3'd2, SHR = 3'd3,
                         ROL  = 3'd4, ROR  = 3'd5, INC = 3'd6, DEC = 3'd7;

  logic        clock;
  logic        reset_n, carry_in;
  logic [2:0]  mode;
  logic [7:0]  in;
  logic [7:0]  out;
  logic        carry_out, zero, negative;

  logic        rst16_n, cin16;
  logic [2:0]  mode16;
  logic [15:0] in16, out16;
  logic        c16, z16, n16;

  int checks = 0;
  int errors = 0;

  register_fall_shift_nb #(.WIDTH(8), .RESET_VALUE(8'h80)) dut8 (
    .clock(clock), .reset_n(reset_n), .mode(mode), .in(in), .carry_in(carry_in),
    .out(out), .carry_out(carry_out), .zero(zero), .negative(negative)
  );

  register_fall_shift_nb #(.WIDTH(16), .RESET_VALUE(16'h0000)) dut16 (
    .clock(clock), .reset_n(rst16_n), .mode(mode16), .in(in16), .carry_in(cin16),
    .out(out16), .carry_out(c16), .zero(z16), .negative(n16)
  );

  initial clock = 1'b1;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one falling edge and sample just after it.
  task automatic fall();
    @(negedge clock);
    #1;
  endtask

  task automatic op(input logic [2:0] m, input logic [7:0] d, input logic ci);
    mode = m; in = d; carry_in = ci;
    fall();
  endtask

  task automatic st(input string tag, input logic [7:0] o, input logic c,
                    input logic z, input logic n);
    chk({tag, ".out"},  {24'h0, out}, {24'h0, o});
    chk({tag, ".c"},    {31'h0, carry_out}, {31'h0, c});
    chk({tag, ".z"},    {31'h0, zero}, {31'h0, z});
    chk({tag, ".n"},    {31'h0, negative}, {31'h0, n});
  endtask

  initial begin
    reset_n = 1'b0; mode = LOAD; in = 8'h55; carry_in = 1'b0;
    rst16_n = 1'b0; mode16 = HOLD; in16 = 16'h0; cin16 = 1'b0;

    // 1 Reset overrides LOAD
    fall();
    st("reset", 8'h80, 1'b0, 1'b0, 1'b1);
    reset_n = 1'b1; mode = HOLD;
    @(posedge clock); #1;
    mode = LOAD; in = 8'h12;         // changes in the high phase only
    #2;
    chk("highphase.out", {24'h0, out}, 32'h80);
    mode = HOLD;
    fall();
    chk("hold_after_high.out", {24'h0, out}, 32'h80);

    // 2 Load / hold
    op(LOAD, 8'h00, 1'b0);
    st("load00", 8'h00, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) op(HOLD, 8'hFF, 1'b1);
    st("hold3", 8'h00, 1'b0, 1'b1, 1'b0);
    @(posedge clock); #1;
    chk("rise_only.out", {24'h0, out}, 32'h00);

    // 3 Shifts
    op(LOAD, 8'h81, 1'b0); st("load81", 8'h81, 1'b0, 1'b0, 1'b1);
    op(SHL,  8'h00, 1'b0); st("shl",    8'h02, 1'b1, 1'b0, 1'b0);
    op(SHR,  8'h00, 1'b0); st("shr1",   8'h01, 1'b0, 1'b0, 1'b0);
    op(SHR,  8'h00, 1'b0); st("shr2",   8'h00, 1'b1, 1'b1, 1'b0);

    // 4 Rotates (carry_out stays 1 from the SHR above through LOAD)
    op(LOAD, 8'h01, 1'b1); st("load01", 8'h01, 1'b1, 1'b0, 1'b0);
    op(ROR,  8'h00, 1'b1); st("ror",    8'h80, 1'b1, 1'b0, 1'b1);
    op(ROL,  8'h00, 1'b0); st("rol",    8'h00, 1'b1, 1'b1, 1'b0);
    op(ROL,  8'h00, 1'b1); st("rol_ci", 8'h01, 1'b0, 1'b0, 1'b0);

    // 5 Wrap; carry_out is 0 going in and must survive INC/DEC
    op(LOAD, 8'hFF, 1'b0); st("loadFF", 8'hFF, 1'b0, 1'b0, 1'b1);
    op(INC,  8'h00, 1'b1); st("inc",    8'h00, 1'b0, 1'b1, 1'b0);
    op(DEC,  8'h00, 1'b1); st("dec",    8'hFF, 1'b0, 1'b0, 1'b1);
    op(SHR,  8'h00, 1'b0); st("shrFF",  8'h7F, 1'b1, 1'b0, 1'b0);
    op(INC,  8'h00, 1'b0); st("inc7F",  8'h80, 1'b1, 1'b0, 1'b1);

    // 6 Reset mid-op
    op(LOAD, 8'h40, 1'b0); st("load40", 8'h40, 1'b1, 1'b0, 1'b0);
    reset_n = 1'b0;
    op(SHL, 8'h00, 1'b0);  st("rst_mid", 8'h80, 1'b0, 1'b0, 1'b1);
    reset_n = 1'b1;
    op(SHL, 8'h00, 1'b0);  st("resume", 8'h00, 1'b1, 1'b1, 1'b0);

    // WIDTH=16 instance
    fall();
    chk("w16.reset.out", {16'h0, out16}, 32'h0);
    chk("w16.reset.z",   {31'h0, z16}, 32'h1);
    rst16_n = 1'b1; mode16 = LOAD; in16 = 16'h8000;
    fall();
    chk("w16.load.out", {16'h0, out16}, 32'h8000);
    chk("w16.load.n",   {31'h0, n16}, 32'h1);
    mode16 = SHL; in16 = 16'h0;
    fall();
    chk("w16.shl.out", {16'h0, out16}, 32'h0);
    chk("w16.shl.c",   {31'h0, c16}, 32'h1);
    chk("w16.shl.z",   {31'h0, z16}, 32'h1);
    chk("w16.shl.n",   {31'h0, n16}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
